// File: rtl/abs_stream_acc.sv
// Unary-to-binary accumulator: counts abs=1 and sign=1 bits over windows of 2^WIDTH
// accepted pairs and presents each window result through a one-entry valid/ready buffer.
module abs_stream_acc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic             abs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_mag,
  output logic [WIDTH:0]   out_neg,
  output logic             out_sign
);

  localparam int unsigned CW = WIDTH + 1;

  logic [WIDTH-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0]    mag_q, mag_d;
  logic [CW-1:0]    neg_q, neg_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    out_mag_q, out_mag_d;
  logic [CW-1:0]    out_neg_q, out_neg_d;
  logic             out_sign_q, out_sign_d;

  logic last_c;
  logic acc_c;
  logic drain_c;

  // Only the window-final bit can stall, and only while an unread result is held.
  assign last_c   = &wcnt_q;
  assign drain_c  = out_valid_q & out_ready;
  assign in_ready = ~(last_c & out_valid_q & ~out_ready);
  assign acc_c    = in_valid & in_ready;

  // Window accumulation and result buffer next state.
  always_comb begin
    wcnt_d      = wcnt_q;
    mag_d       = mag_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    out_mag_d   = out_mag_q;
    out_neg_d   = out_neg_q;
    out_sign_d  = out_sign_q;

    if (drain_c) begin
      out_valid_d = 1'b0;
    end

    if (acc_c) begin
      if (last_c) begin
        out_mag_d   = mag_q + CW'(abs);
        out_neg_d   = neg_q + CW'(sign);
        out_sign_d  = sign;
        out_valid_d = 1'b1;
        wcnt_d      = '0;
        mag_d       = '0;
        neg_d       = '0;
      end else begin
        wcnt_d = wcnt_q + WIDTH'(1);
        mag_d  = mag_q + CW'(abs);
        neg_d  = neg_q + CW'(sign);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q      <= '0;
      mag_q       <= '0;
      neg_q       <= '0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_neg_q   <= '0;
      out_sign_q  <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_neg_q   <= out_neg_d;
      out_sign_q  <= out_sign_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_neg   = out_neg_q;
  assign out_sign  = out_sign_q;

endmodule

// File: tb/tb_abs_stream_acc.sv
// Directed plus random stimulus for abs_stream_acc at WIDTH=3 and WIDTH=2, checked against
// a window-queue reference model.
module tb_abs_stream_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v3, rdy3, s3, a3, ov3, or3, os3;
  logic [3:0] om3, on3;
  logic       v2, rdy2, s2, a2, ov2, or2, os2;
  logic [2:0] om2, on2;

  abs_stream_acc #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .sign(s3), .abs(a3),
    .out_valid(ov3), .out_ready(or3), .out_mag(om3), .out_neg(on3), .out_sign(os3)
  );

  abs_stream_acc #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .sign(s2), .abs(a2),
    .out_valid(ov2), .out_ready(or2), .out_mag(om2), .out_neg(on2), .out_sign(os2)
  );

  int ncmp  = 0;
  int nfail = 0;
  int wsel  = 3;

  // Reference model: bits of the open window, plus the one-entry result buffer.
  bit q_s[$];
  bit q_a[$];
  bit mv;
  int mm, mn;
  bit ms;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] o_valid();
    return (wsel == 3) ? 32'(ov3) : 32'(ov2);
  endfunction
  function automatic logic [31:0] o_mag();
    return (wsel == 3) ? 32'(om3) : 32'(om2);
  endfunction
  function automatic logic [31:0] o_neg();
    return (wsel == 3) ? 32'(on3) : 32'(on2);
  endfunction
  function automatic logic [31:0] o_sign();
    return (wsel == 3) ? 32'(os3) : 32'(os2);
  endfunction
  function automatic logic [31:0] o_rdy();
    return (wsel == 3) ? 32'(rdy3) : 32'(rdy2);
  endfunction

  task automatic check_outs();
    chk("out_valid", o_valid(), 32'(mv));
    if (mv) begin
      chk("out_mag", o_mag(), 32'(mm));
      chk("out_neg", o_neg(), 32'(mn));
      chk("out_sign", o_sign(), 32'(ms));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v3 = 1'b0; s3 = 1'b0; a3 = 1'b0; or3 = 1'b0;
    v2 = 1'b0; s2 = 1'b0; a2 = 1'b0; or2 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_s.delete();
    q_a.delete();
    mv = 1'b0; mm = 0; mn = 0; ms = 1'b0;
    chk("rst_valid", o_valid(), 32'd0);
    chk("rst_mag", o_mag(), 32'd0);
    chk("rst_neg", o_neg(), 32'd0);
    chk("rst_sign", o_sign(), 32'd0);
    #1;
    chk("rst_in_ready", o_rdy(), 32'd1);
  endtask

  // One clock: drive, check in_ready, clock, advance model, check outputs.
  task automatic cyc(input bit v, input bit s, input bit a, input bit r);
    bit erdy, acc, drain;
    int win;
    win = 1 << wsel;
    if (wsel == 3) begin
      v3 = v; s3 = s; a3 = a; or3 = r;
      v2 = 1'b0; s2 = 1'b0; a2 = 1'b0; or2 = 1'b0;
    end else begin
      v2 = v; s2 = s; a2 = a; or2 = r;
      v3 = 1'b0; s3 = 1'b0; a3 = 1'b0; or3 = 1'b0;
    end
    #1;
    erdy = !((q_a.size() == win - 1) && mv && !r);
    chk("in_ready", o_rdy(), 32'(erdy));
    acc   = v && erdy;
    drain = mv && r;
    @(posedge clk);
    #1;
    if (drain) mv = 1'b0;
    if (acc) begin
      q_s.push_back(s);
      q_a.push_back(a);
      if (q_a.size() == win) begin
        mm = 0;
        mn = 0;
        foreach (q_a[i]) begin
          mm += int'(q_a[i]);
          mn += int'(q_s[i]);
        end
        ms = s;
        mv = 1'b1;
        q_s.delete();
        q_a.delete();
      end
    end
    check_outs();
  endtask

  initial begin
    bit ps[8];
    bit pa[8];
    bit fs, fa;
    ps = '{1, 1, 1, 0, 0, 0, 0, 1};
    pa = '{1, 0, 1, 1, 0, 0, 1, 0};

    wsel = 3;
    do_reset();

    // All-ones magnitude window.
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 1);
    chk("ones_mag_fixed", o_mag(), 32'd8);
    cyc(0, 0, 0, 1);

    // Mixed pattern: mag 4, neg 4, final sign 1.
    for (int i = 0; i < 8; i++) cyc(1, ps[i], pa[i], 1);
    chk("pat_mag_fixed", o_mag(), 32'd4);
    chk("pat_neg_fixed", o_neg(), 32'd4);
    chk("pat_sign_fixed", o_sign(), 32'd1);
    cyc(0, 0, 0, 1);
    chk("pat_valid_drop", o_valid(), 32'd0);

    // Gapped input.
    for (int i = 0; i < 16; i++) cyc((i % 2) == 0, 0, 1, 1);
    cyc(0, 0, 0, 1);

    // Two windows under backpressure, stall on final bit, then drain and reload together.
    for (int i = 0; i < 15; i++) cyc(1, 1'($urandom), 1'($urandom), 0);
    fs = 1'($urandom);
    fa = 1'($urandom);
    cyc(1, fs, fa, 0);
    chk("stall_in_ready", o_rdy(), 32'd0);
    cyc(1, fs, fa, 1);
    chk("reload_valid", o_valid(), 32'd1);
    cyc(0, 0, 0, 1);

    // Reset mid-window discards partial counts.
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 1);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, (i < 3), 1);
    chk("post_rst_mag", o_mag(), 32'd3);
    chk("post_rst_neg", o_neg(), 32'd0);
    cyc(0, 0, 0, 1);

    // Random traffic at WIDTH=3.
    for (int i = 0; i < 300; i++)
      cyc(($urandom % 4) != 0, 1'($urandom), 1'($urandom), ($urandom % 3) != 0);

    // WIDTH=2 boundaries: empty then full-scale window.
    wsel = 2;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);
    chk("w2_zero_mag", o_mag(), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 1);
    chk("w2_full_mag", o_mag(), 32'd4);
    chk("w2_full_neg", o_neg(), 32'd4);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 300; i++)
      cyc(($urandom % 4) != 0, 1'($urandom), 1'($urandom), ($urandom % 3) != 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
